// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one subtract cell stepped LSB-first over WIDTH cycles.
// Start/done handshake; D and bOut are registered and only change on completion or reset.

module sub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bo
);
   assign d  = a ^ b ^ bin;
   assign bo = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtract_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             bOut
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic             cell_d, cell_bo;

   sub_cell u_cell (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .bin (borrow),
      .d   (cell_d),
      .bo  (cell_bo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         D      <= '0;
         bOut   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= A;
                  b_sr   <= B;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               // result fills from the MSB end so bit 0 lands in place after WIDTH shifts
               res_sr <= {cell_d, res_sr[WIDTH-1:1]};
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               borrow <= cell_bo;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  D     <= {cell_d, res_sr[WIDTH-1:1]};
                  bOut  <= cell_bo;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Scoreboard bench for serial_subtract_ctrl (WIDTH=8): expected results queued at start, popped at done.

module tb_serial_subtract_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] A, B, D;
   logic         busy, done, bOut;

   typedef struct packed {
      logic [W-1:0] d;
      logic         b;
   } res_t;

   res_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   serial_subtract_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .bOut  (bOut)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] t;
      res_t r;
      t   = {1'b0, a} - {1'b0, b};
      r.d = t[W-1:0];
      r.b = t[W];
      return r;
   endfunction

   // one operation with busy/done timing checks; disturb pokes start/A/B mid-run
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
      res_t e;
      int   n;
      A = a; B = b; start = 1'b1;
      exp_q.push_back(model(a, b));
      cyc();
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < W + 4) begin
         n_tests++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_run cycle %0d: got %b expected 1", n, busy);
         end
         if (disturb && n == 2) begin start = 1'b1; A = 8'h01; B = 8'h02; end
         if (disturb && n == 3) begin start = 1'b0; A = 8'hff; B = 8'h77; end
         cyc();
         n++;
      end
      n_tests++;
      if (n !== W) begin
         n_fail++;
         $display("FAIL done_latency: got %0d cycles expected %0d", n, W);
      end
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (done === 1'b1) begin
         n_tests++;
         if (D !== e.d || bOut !== e.b) begin
            n_fail++;
            $display("FAIL result %h-%h: got D=%h bOut=%b expected D=%h bOut=%b", a, b, D, bOut, e.d, e.b);
         end
         n_tests++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_done: got %b expected 0", busy);
         end
      end
      cyc();
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_width: got %b expected 0", done);
      end
      if (disturb) begin
         for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (busy !== 1'b0 || D !== e.d) begin
               n_fail++;
               $display("FAIL no_second_op: got busy=%b D=%h expected busy=0 D=%h", busy, D, e.d);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      cyc(); cyc();
      rst = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || D !== '0 || bOut !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b D=%h bOut=%b expected 0 0 00 0", busy, done, D, bOut);
      end
      cyc();
   endtask

   task automatic test_arith();
      logic [W-1:0] av [6] = '{8'h35, 8'h12, 8'h00, 8'hAA, 8'hFF, 8'h01};
      logic [W-1:0] bv [6] = '{8'h12, 8'h35, 8'h01, 8'hAA, 8'h00, 8'hFF};
      for (int i = 0; i < 6; i++) do_op(av[i], bv[i], 1'b0);
   endtask

   task automatic test_ignore_start();
      do_op(8'h50, 8'h20, 1'b1);
   endtask

   task automatic test_reset_abort();
      A = 8'h80; B = 8'h01; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || D !== '0 || bOut !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: got busy=%b done=%b D=%h bOut=%b expected 0 0 00 0", busy, done, D, bOut);
      end
      for (int i = 0; i < W + 2; i++) begin
         cyc();
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got done=%b busy=%b expected 0 0", done, busy);
         end
      end
      do_op(8'h80, 8'h01, 1'b0);
   endtask

   task automatic test_back_to_back();
      res_t         e;
      logic [W-1:0] d_hold;
      bit           exp_busy, exp_done;
      d_hold = D;
      A = 8'h10; B = 8'h20; start = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h10, 8'h20));
      for (int k = 1; k <= 30; k++) begin
         cyc();
         exp_busy = (k % 10 >= 1) && (k % 10 <= 8);
         exp_done = (k % 10 == 9);
         n_tests++;
         if (busy !== exp_busy || done !== exp_done) begin
            n_fail++;
            $display("FAIL b2b_timing k=%0d: got busy=%b done=%b expected %b %b", k, busy, done, exp_busy, exp_done);
         end
         if (done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d_hold = e.d;
            n_tests++;
            if (D !== e.d || bOut !== e.b) begin
               n_fail++;
               $display("FAIL b2b_result k=%0d: got D=%h bOut=%b expected D=%h bOut=%b", k, D, bOut, e.d, e.b);
            end
         end else begin
            n_tests++;
            if (D !== d_hold) begin
               n_fail++;
               $display("FAIL b2b_hold k=%0d: got D=%h expected %h", k, D, d_hold);
            end
         end
      end
      start = 1'b0;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d results outstanding expected 0", exp_q.size());
      end
      cyc(); cyc();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
Bit-serial N-bit subtractor controller. It owns one 1-bit subtract cell: a half-subtract pair plus a borrow-chain OR, d = a^b^bin, bo = (~a&b) | (~(a^b)&bin). It sequences that cell LSB-first over WIDTH cycles to produce D = A - B and the final borrow. It sits between a requester (start/done handshake) and the bit cell, and provides a registered result.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend; captured on accepted start
B  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while operation in progress (RUN)
done  output  1  one-cycle pulse: D/bOut valid and newly updated
D  output  WIDTH  difference A - B modulo 2^WIDTH, registered
bOut  output  1  final borrow (1 when A < B unsigned), registered

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state -> IDLE.
  - busy=0, done=0, D=0, bOut=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - rst overrides start and every state.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge t0: latch A and B into shift registers, borrow=0, count=0, go to RUN. busy=1 from t0+1.
  - start=0: stay in IDLE. D and bOut hold their previous values.
- RUN (one bit per edge):
  - Compute the cell on the shift-register LSBs with the current borrow.
  - Shift the d bit into the result register from the MSB end. Shift operands right.
  - borrow <= bo; count <= count+1.
  - When count = WIDTH-1 at the edge: transfer the completed result to D, the final bo to bOut, and go to DONE.
  - RUN lasts exactly WIDTH cycles: edges t0+1 .. t0+WIDTH.
- DONE:
  - done=1, busy=0 for exactly one cycle (the cycle after edge t0+WIDTH).
  - Next edge unconditionally -> IDLE.
- Latency: start accepted at edge t0. D/bOut update at edge t0+WIDTH. done is high during the cycle following t0+WIDTH.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- start rules:
  - Ignored in RUN and DONE; no queuing. Operands presented then are not captured.
  - Held high continuously, start is re-accepted at the first IDLE edge.
- Operand changes on A/B after acceptance have no effect on the running operation.
- D and bOut change only at RUN-completion and at reset. They are never partially updated or visible mid-operation.
- Arithmetic is unsigned modulo 2^WIDTH. bOut is the borrow out of the MSB.
- Reset mid-RUN aborts: no done pulse, D/bOut cleared to 0.

Test Plan:
1. WIDTH=8, reset 2 cycles, then start with A=0x35, B=0x12 -> busy high 8 cycles; done pulse at the 9th cycle after acceptance; D=0x23, bOut=0.
2. A=0x12, B=0x35 -> D=0xDD, bOut=1. Also A=0x00, B=0x01 -> D=0xFF, bOut=1 (borrow ripples through all bits).
3. A=0xAA, B=0xAA -> D=0x00, bOut=0. A=0xFF, B=0x00 -> D=0xFF, bOut=0.
4. Start A=0x50, B=0x20. During RUN, pulse start with A=0x01, B=0x02 and also change A/B levels -> result D=0x30, bOut=0; no second operation begins; busy pattern unchanged.
5. Start A=0x80, B=0x01. Assert rst at the 4th RUN cycle for one edge -> busy=0, done never pulses, D=0x00, bOut=0. Subsequent start A=0x80, B=0x01 -> D=0x7F, bOut=0.
6. start held high for 30 cycles with A=0x10, B=0x20 -> back-to-back operations every WIDTH+2 = 10 cycles. Each gives a one-cycle done with D=0xF0, bOut=1. D holds between done pulses.
